four_adder: RTL and testbench

//  - Registered WIDTH-bit two's-complement adder/subtractor, built as a ripple chain of full adders.
//  - Cin selects the operation: 0 = A+tmp, 1 = A-tmp, computed as A + ~tmp + 1.
//  - Produces the sum, the carry-out and a signed overflow flag, all registered.
//  - Arithmetic leaf of the subtractor datapath; driven directly by the top-level operand registers.

---
 rtl/four_adder_if.sv | 23 ++
 rtl/four_adder.sv | 95 +++++++++
 tb/tb_four_adder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/four_adder_if.sv
// Operand/result bus of the registered ripple-carry adder/subtractor.
interface four_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] tmp;
  logic             Cin;
  logic [WIDTH-1:0] So;
  logic             Cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, A, tmp, Cin,
    input  So, Cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, A, tmp, Cin,
    output So, Cout, overflow, out_valid
  );
endinterface

// File: rtl/four_adder.sv
// Registered WIDTH-bit two's-complement adder/subtractor on a ripple chain of full adders.
// Optional signed saturation of the result when FOUR_ADDER_SAT_EN is defined.

module four_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module four_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  four_adder_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] res;

  logic [WIDTH-1:0] so_q,   so_d;
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             vld_q,  vld_d;

  // Subtract is A + ~tmp + 1: invert B and inject Cin as the bit-0 carry.
  assign bx   = bus.tmp ^ {WIDTH{bus.Cin}};
  assign c[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    four_adder_fa u_fa (
      .a_i (bus.A[i]),
      .b_i (bx[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .c_o (c[i+1])
    );
  end

  assign ovf = c[WIDTH] ^ c[MSB];

`ifdef FOUR_ADDER_SAT_EN
  // On overflow the true result's sign is the sign of A.
  always_comb begin
    res = sum;
    if (ovf) begin
      res = bus.A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = sum;
`endif

  // Result registers only load on a valid op, so idle inputs never leak through.
  always_comb begin
    so_d   = so_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (bus.in_valid) begin
      so_d   = res;
      cout_d = c[WIDTH];
      ovf_d  = ovf;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      so_q   <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      so_q   <= so_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.So        = so_q;
  assign bus.Cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_four_adder.sv
// Self-checking bench for four_adder (WIDTH=4) against a signed/unsigned arithmetic model.
module tb_four_adder;
  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [5:0] hold_exp;

  four_adder_if #(.WIDTH(W)) bus ();

  four_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Returns {So, Cout, overflow} from integer arithmetic.
  function automatic logic [5:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int sa, sb, r;
    logic [3:0] so;
    logic co, ov;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    r  = cin ? sa - sb : sa + sb;
    ov = (r > 7) || (r < -8);
    so = 4'(r);
    co = cin ? (a >= b) : ((int'(a) + int'(b)) > 15);
`ifdef FOUR_ADDER_SAT_EN
    if (ov) so = (r > 7) ? 4'b0111 : 4'b1000;
`endif
    return {so, co, ov};
  endfunction

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus.in_valid = v;
    bus.A        = a;
    bus.tmp      = b;
    bus.Cin      = cin;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 4'b1111, 4'b0001, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== 7'b0000_0_0_0) begin
      failures++;
      $display("FAIL reset: got So=%b Cout=%b ovf=%b vld=%b, expected 0000 0 0 0",
               bus.So, bus.Cout, bus.overflow, bus.out_valid);
    end
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    hold_exp = 6'b0;
  endtask

  task automatic directed(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [5:0] exp);
    drive(1'b1, a, b, cin);
    @(negedge clk);
    drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    checks++;
    if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== {exp, 1'b1}) begin
      failures++;
      $display("FAIL %s: got So=%b Cout=%b ovf=%b vld=%b, expected So=%b Cout=%b ovf=%b vld=1",
               name, bus.So, bus.Cout, bus.overflow, bus.out_valid, exp[5:2], exp[1], exp[0]);
    end
    hold_exp = exp;
  endtask

  task automatic test_directed;
`ifdef FOUR_ADDER_SAT_EN
    localparam logic [3:0] POS_OVF_SO = 4'b0111;
    localparam logic [3:0] NEG_OVF_SO = 4'b1000;
`else
    localparam logic [3:0] POS_OVF_SO = 4'b1000;
    localparam logic [3:0] NEG_OVF_SO = 4'b0111;
`endif
    directed("add",     4'b0000, 4'b1000, 1'b0, {4'b1000, 1'b0, 1'b0});
    directed("sub",     4'b1111, 4'b1000, 1'b1, {4'b0111, 1'b1, 1'b0});
    directed("pos_ovf", 4'b0111, 4'b0001, 1'b0, {POS_OVF_SO, 1'b0, 1'b1});
    directed("neg_ovf", 4'b1000, 4'b0001, 1'b1, {NEG_OVF_SO, 1'b1, 1'b1});
    directed("wrap",    4'b1111, 4'b0001, 1'b0, {4'b0000, 1'b1, 1'b0});
    directed("sub_eq",  4'b0101, 4'b0101, 1'b1, {4'b0000, 1'b1, 1'b0});
  endtask

  task automatic test_hold;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      @(negedge clk);
      checks++;
      if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== {hold_exp, 1'b0}) begin
        failures++;
        $display("FAIL hold[%0d]: got So=%b Cout=%b ovf=%b vld=%b, expected So=%b Cout=%b ovf=%b vld=0",
                 k, bus.So, bus.Cout, bus.overflow, bus.out_valid, hold_exp[5:2], hold_exp[1], hold_exp[0]);
      end
    end
  endtask

  // All 512 combos, shuffled, issued back-to-back every cycle.
  task automatic test_sweep;
    int order [512];
    logic [5:0] exp;
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    exp = 6'b0;
    for (int k = 0; k <= 512; k++) begin
      if (k < 512) begin
        logic [8:0] v;
        v = 9'(order[k]);
        drive(1'b1, v[3:0], v[7:4], v[8]);
      end else begin
        drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      end
      if (k > 0) begin
        checks++;
        if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== {exp, 1'b1}) begin
          failures++;
          $display("FAIL sweep[%0d]: got So=%b Cout=%b ovf=%b vld=%b, expected So=%b Cout=%b ovf=%b vld=1",
                   k - 1, bus.So, bus.Cout, bus.overflow, bus.out_valid, exp[5:2], exp[1], exp[0]);
        end
      end
      if (k < 512) exp = ref_op(bus.A, bus.tmp, bus.Cin);
      @(negedge clk);
    end
    hold_exp = exp;
  endtask

  // Random valid/idle mix; idle cycles must hold the last result.
  task automatic test_random;
    logic [5:0] exp;
    logic       vld;
    exp = hold_exp;
    for (int k = 0; k < 300; k++) begin
      vld = ($urandom_range(3, 0) != 0);
      drive(vld, 4'($urandom), 4'($urandom), 1'($urandom));
      if (vld) exp = ref_op(bus.A, bus.tmp, bus.Cin);
      @(negedge clk);
      checks++;
      if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== {exp, vld}) begin
        failures++;
        $display("FAIL random[%0d]: got So=%b Cout=%b ovf=%b vld=%b, expected So=%b Cout=%b ovf=%b vld=%b",
                 k, bus.So, bus.Cout, bus.overflow, bus.out_valid, exp[5:2], exp[1], exp[0], vld);
      end
    end
    hold_exp = exp;
  endtask

  // An op presented in a reset cycle is discarded.
  task automatic test_reset_midstream;
    directed("pre_rst", 4'b0011, 4'b0010, 1'b0, {4'b0101, 1'b0, 1'b0});
    rst_n = 1'b0;
    drive(1'b1, 4'b0111, 4'b0111, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== 7'b0) begin
      failures++;
      $display("FAIL mid_rst: got So=%b Cout=%b ovf=%b vld=%b, expected 0000 0 0 0",
               bus.So, bus.Cout, bus.overflow, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.So, bus.Cout, bus.overflow, bus.out_valid} !== 7'b0) begin
      failures++;
      $display("FAIL mid_rst_hold: got So=%b Cout=%b ovf=%b vld=%b, expected 0000 0 0 0",
               bus.So, bus.Cout, bus.overflow, bus.out_valid);
    end
    hold_exp = 6'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hold_exp = 6'b0;
    rst_n    = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    test_reset;
    test_directed;
    test_hold;
    test_sweep;
    test_hold;
    test_random;
    test_reset_midstream;
    test_directed;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
